// File: rtl/detector_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : detector_scheduler
// Description : Round-robin scheduler sharing one external serial
//               "three-or-more 1s then 0" detector among N requesters.
//               The winner's word is shifted MSB-first into the detector
//               after a mandatory detector clear. Detections are counted and
//               returned with a one-cycle done pulse.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req[N]            - level requests, held until granted
//               data[N*W]         - requester i word at [i*W +: W]
//               gnt[N]            - registered one-hot grant, CLEAR..DONE
//               busy, done        - not-idle flag, one-cycle completion pulse
//               match_cnt[CW]     - detection count of last completed job
//               det_clr, det_x    - detector clear and serial bit
//               det_detected      - detector Moore output (previous bit)
// Revision    : 1.0 - initial release
// ============================================================================
module detector_scheduler #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  match_cnt,
  output logic           det_clr,
  output logic           det_x,
  input  logic           det_detected
);

  localparam int PW = $clog2(N);
  localparam int BW = $clog2(W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [BW-1:0] c_last_bit = BW'(W - 1);
  localparam logic [PW-1:0] c_last_req = PW'(N - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic [N-1:0]  r_gnt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_win;
  logic [W-1:0]  r_shift;
  logic [BW-1:0] r_bit_cnt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_match_cnt;

  logic          w_found;
  logic [PW-1:0] w_win;
  logic [W-1:0]  w_word;
  logic [N-1:0]  w_onehot;

  // Rotating priority scan: first set request at or after r_ptr, wrapping.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    w_word  = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
        w_word  = data[idx*W +: W];
      end
    end
  end

  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next_state = S_CLEAR;
      S_CLEAR: w_next_state = S_SHIFT;
      S_SHIFT: if (r_bit_cnt == c_last_bit) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    det_clr = (r_state == S_CLEAR);
    det_x   = (r_state == S_SHIFT) && r_shift[W-1];
  end

  // Datapath: grant, word capture, bit/match counting, pointer update.
  // The detector output lags the applied bit by one cycle, so the count
  // accumulates through SHIFT and picks up the final bit's result in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_win       <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_count     <= '0;
      r_match_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_onehot;
            r_win   <= w_win;
            r_shift <= w_word;
          end
        end
        S_CLEAR: begin
          r_count   <= '0;
          r_bit_cnt <= '0;
        end
        S_SHIFT: begin
          r_shift   <= r_shift << 1;
          r_bit_cnt <= r_bit_cnt + BW'(1);
          r_count   <= r_count + CW'(det_detected);
        end
        S_DRAIN: begin
          r_count     <= r_count + CW'(det_detected);
          r_match_cnt <= r_count + CW'(det_detected);
        end
        S_DONE: begin
          r_gnt <= '0;
          r_ptr <= (r_win == c_last_req) ? '0 : r_win + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign match_cnt = r_match_cnt;

endmodule
`default_nettype wire

// File: doc/detector_scheduler.md
Name: detector_scheduler

Overview:
- Round-robin scheduler that shares one serial "three-or-more 1s then 0" pattern detector among N requesters.
- Each requester submits a W-bit word. The block arbitrates, clears the detector, shifts the word MSB-first into it, counts detections, and returns the count with a done pulse to the granted requester.
- The detector instance sits outside this block. Its clk is shared, and its rst is driven by (rst | det_clr).

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, word width in bits (4..32).
- CW, $clog2(W+1), match counter width (localparam, derived).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request, level. Requester holds req and its data until it sees its gnt bit.
- data  in  N*W  requester i word at bits [i*W +: W].
- gnt  out  N  one-hot grant, registered; held from CLEAR through DONE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in DONE.
- match_cnt  out  CW  detection count of the last completed job.
- det_clr  out  1  detector clear; high only in CLEAR.
- det_x  out  1  serial bit to detector; 0 outside SHIFT.
- det_detected  in  1  detector Moore output. Reflects the bit applied on the previous cycle.

Behaviour:
- Reset (sync, active-high): state=IDLE, gnt=0, busy=0, done=0, match_cnt=0, det_clr=0, det_x=0, rr pointer=0 (req[0] highest priority). Reset mid-job aborts the job immediately; no done is issued.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - If req≠0, pick the first set req index scanning from ptr upward with wrap.
  - Latch data of the winner into the shift register, set gnt one-hot, go to CLEAR.
  - If req=0, stay in IDLE.
- CLEAR (1 cycle): det_clr=1, count cleared to 0, bit counter=0. Go to SHIFT.
- SHIFT (W cycles):
  - Cycle k (k=0..W-1) drives det_x = word bit W-1-k.
  - count += det_detected each cycle (cycle 0 sees the cleared detector, so the detector presents 0).
  - After k=W-1, go to DRAIN.
- DRAIN (1 cycle): det_x=0; count += det_detected, which captures the result of the last bit. Go to DONE.
- DONE (1 cycle):
  - done=1, match_cnt=final count, gnt still asserted.
  - ptr = winner index + 1 mod N. Go to IDLE.
- Latency: arbitration cycle t → done at cycle t+W+3. Minimum one IDLE cycle between jobs, so throughput is 1 job per W+4 cycles.
- match_cnt holds its value from DONE until the next job's DONE. It is not updated mid-job.
- req and data changes after the grant cycle are ignored. Deassertion of req by the granted requester does not abort the job.
- A non-granted req stays pending and is not lost.
- Count never saturates: max detections is ceil(W/4) < 2^CW.
- A detector clear before every job is mandatory, so detector state never carries across jobs.

Test Plan:
- W=8, req=0001, data0=8'hEE → gnt=0001, det_x sequence 1,1,1,0,1,1,1,0. done at t+11, match_cnt=2 (second detection sampled in DRAIN).
- data0=8'hF0 → match_cnt=1. data0=8'h77 → match_cnt=1. data0=8'h00 → match_cnt=0.
- Carry-over check: job0 data=8'h07 (ends in 111), then job1 data=8'h00 → both give match_cnt=0. The 0 leading job1 must not detect, because of det_clr.
- req=1111 held constant → grant order 0001, 0010, 0100, 1000, 0001. One done per W+4 cycles; each grant is asserted exactly during its CLEAR..DONE window.
- Requester 2 drops req mid-SHIFT while req[0] rises → job 2 completes with correct count, then 0001 is granted.
- rst asserted during SHIFT bit 4 → next cycle all outputs are zero and state=IDLE, with no done. After release, req=0100 is granted first only if req[0] and req[1] are low (ptr=0).
